// File: rtl/fetch_align_if.sv
// Fetch-side bus bundle: redirect, memory request/response and decode handshake.
// The master modport is the align buffer; the slave modport is the surrounding core/memory.
interface fetch_align_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic [XLEN-1:0] flush_pc_i;
    logic            req_valid_o;
    logic [XLEN-1:0] req_addr_o;
    logic            req_ready_i;
    logic            resp_valid_i;
    logic [31:0]     resp_data_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_compressed_o;
    logic            instr_ready_i;

    modport master (
        input  flush_i, flush_pc_i, req_ready_i, resp_valid_i, resp_data_i, instr_ready_i,
        output req_valid_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
    );

    modport slave (
        output flush_i, flush_pc_i, req_ready_i, resp_valid_i, resp_data_i, instr_ready_i,
        input  req_valid_o, req_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// Halfword-granular fetch buffer: issues word fetches, stores parcels in a circular FIFO
// and presents complete 16/32-bit instructions with their PC to decode.
module fetch_align_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input logic            clk,
    input logic            rst,
    fetch_align_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C        = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  RESET_FETCH    = RESET_PC & ~XLEN'(3);
    localparam logic [XLEN-1:0]  RESET_INSTR_PC = RESET_PC & ~XLEN'(1);

    logic [15:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             outstanding_q, outstanding_d;
    logic             drop_q, drop_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0]  pc_q, pc_d;

    logic [15:0]      head_lo_s;
    logic [15:0]      head_hi_s;
    logic             head_comp_s;
    logic [CNT_W-1:0] free_s;
    logic             req_valid_s;
    logic             instr_valid_s;
    logic             req_fire_s;
    logic             resp_take_s;
    logic             resp_write_s;
    logic             pop_s;
    logic [CNT_W-1:0] wr_n_s;
    logic [CNT_W-1:0] pop_n_s;
    logic [XLEN-1:0]  pc_inc_s;

    assign head_lo_s   = fifo_q[rd_ptr_q];
    assign head_hi_s   = fifo_q[rd_ptr_q + PTR_W'(1)];
    assign head_comp_s = (head_lo_s[1:0] != 2'b11);
    assign free_s      = DEPTH_C - count_q;

    // A request is only issued when a whole word fits, so responses can never overflow.
    assign req_valid_s   = !outstanding_q && (free_s >= CNT_W'(2)) && !bus.flush_i && !rst;
    assign instr_valid_s = !rst && ((count_q >= CNT_W'(2)) ||
                                    ((count_q != {CNT_W{1'b0}}) && head_comp_s));

    assign req_fire_s   = req_valid_s && bus.req_ready_i;
    assign resp_take_s  = bus.resp_valid_i && outstanding_q;
    assign resp_write_s = resp_take_s && !drop_q && !bus.flush_i && !rst;
    assign pop_s        = instr_valid_s && bus.instr_ready_i && !bus.flush_i;

    // Per-cycle FIFO occupancy deltas and PC advance.
    always_comb begin
        wr_n_s   = {CNT_W{1'b0}};
        pop_n_s  = {CNT_W{1'b0}};
        pc_inc_s = {XLEN{1'b0}};
        if (resp_write_s) begin
            wr_n_s = misalign_q ? CNT_W'(1) : CNT_W'(2);
        end else begin
            wr_n_s = {CNT_W{1'b0}};
        end
        if (pop_s) begin
            pop_n_s  = head_comp_s ? CNT_W'(1) : CNT_W'(2);
            pc_inc_s = head_comp_s ? XLEN'(2) : XLEN'(4);
        end else begin
            pop_n_s  = {CNT_W{1'b0}};
            pc_inc_s = {XLEN{1'b0}};
        end
    end

    // Next-state logic; a redirect overrides consume and response in the same cycle.
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        misalign_d    = misalign_q;
        fetch_addr_d  = fetch_addr_q;
        pc_d          = pc_q;
        if (bus.flush_i) begin
            rd_ptr_d     = {PTR_W{1'b0}};
            wr_ptr_d     = {PTR_W{1'b0}};
            count_d      = {CNT_W{1'b0}};
            pc_d         = bus.flush_pc_i & ~XLEN'(1);
            fetch_addr_d = bus.flush_pc_i & ~XLEN'(3);
            misalign_d   = bus.flush_pc_i[1];
            // A response landing in the flush cycle is the stale one itself: nothing left to drop.
            outstanding_d = outstanding_q && !bus.resp_valid_i;
            drop_d        = outstanding_q && !bus.resp_valid_i;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_n_s);
            count_d  = count_q + wr_n_s - pop_n_s;
            pc_d     = pc_q + pc_inc_s;
            if (req_fire_s) begin
                outstanding_d = 1'b1;
                fetch_addr_d  = fetch_addr_q + XLEN'(4);
            end else if (resp_take_s) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                misalign_d    = drop_q ? misalign_q : 1'b0;
            end else begin
                outstanding_d = outstanding_q;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= {PTR_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            misalign_q    <= RESET_PC[1];
            fetch_addr_q  <= RESET_FETCH;
            pc_q          <= RESET_INSTR_PC;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            misalign_q    <= misalign_d;
            fetch_addr_q  <= fetch_addr_d;
            pc_q          <= pc_d;
        end
    end

    // Parcel storage; a misaligned first word keeps only its upper halfword.
    always_ff @(posedge clk) begin
        if (resp_write_s) begin
            if (misalign_q) begin
                fifo_q[wr_ptr_q] <= bus.resp_data_i[31:16];
            end else begin
                fifo_q[wr_ptr_q]               <= bus.resp_data_i[15:0];
                fifo_q[wr_ptr_q + PTR_W'(1)]   <= bus.resp_data_i[31:16];
            end
        end
    end

    assign bus.req_valid_o        = req_valid_s;
    assign bus.req_addr_o         = fetch_addr_q;
    assign bus.instr_valid_o      = instr_valid_s;
    assign bus.instr_o            = head_comp_s ? {16'h0000, head_lo_s} : {head_hi_s, head_lo_s};
    assign bus.instr_pc_o         = pc_q;
    assign bus.instr_compressed_o = head_comp_s;
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: directed vector table, hand sequences on a DEPTH=4 copy,
// and random traffic checked against a queue-based reference model.
module tb_fetch_align_buffer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    fetch_align_if #(.XLEN(32)) bus8 ();
    fetch_align_if #(.XLEN(32)) bus4 ();

    fetch_align_buffer #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8));
    fetch_align_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic        r;
        logic        fl;
        logic [31:0] fpc;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_comp;
        logic        chk_pc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, fl, input logic [31:0] fpc, input logic rr, rv,
                                input logic [31:0] rd, input logic ir, er, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] ei, ep, input logic ec, cp);
        vec_t v;
        v.r = r; v.fl = fl; v.fpc = fpc; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_req = er; v.e_addr = ea; v.e_iv = eiv; v.e_instr = ei; v.e_pc = ep;
        v.e_comp = ec; v.chk_pc = cp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic fl, input logic [31:0] fpc, input logic rr, rv,
                          input logic [31:0] rd, input logic ir);
        bus8.flush_i = fl; bus8.flush_pc_i = fpc; bus8.req_ready_i = rr;
        bus8.resp_valid_i = rv; bus8.resp_data_i = rd; bus8.instr_ready_i = ir;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rst = v.r;
        drive8(v.fl, v.fpc, v.rr, v.rv, v.rd, v.ir);
        #1;
        check1($sformatf("vec%0d req_valid", idx), bus8.req_valid_o, v.e_req);
        if (v.e_req) check($sformatf("vec%0d req_addr", idx), bus8.req_addr_o, v.e_addr);
        check1($sformatf("vec%0d instr_valid", idx), bus8.instr_valid_o, v.e_iv);
        if (v.e_iv) begin
            check($sformatf("vec%0d instr", idx), bus8.instr_o, v.e_instr);
            check($sformatf("vec%0d instr_pc", idx), bus8.instr_pc_o, v.e_pc);
            check1($sformatf("vec%0d compressed", idx), bus8.instr_compressed_o, v.e_comp);
        end else if (v.chk_pc) begin
            check($sformatf("vec%0d instr_pc", idx), bus8.instr_pc_o, v.e_pc);
        end
        tick();
    endtask

    // Reference model state: parcel queue plus fetch bookkeeping.
    logic [15:0] mq[$];
    logic [31:0] m_pc, m_fa;
    logic        m_out, m_drop, m_mis;

    initial begin
        logic        r, fl, rr, rv, ir, m_req, m_iv, pend;
        logic [31:0] fpc, rd, e_instr;
        logic [15:0] h0;
        int          dly;

        rst = 1'b1;
        drive8(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        bus4.flush_i = 1'b0; bus4.flush_pc_i = 32'h0; bus4.req_ready_i = 1'b0;
        bus4.resp_valid_i = 1'b0; bus4.resp_data_i = 32'h0; bus4.instr_ready_i = 1'b0;
        tick();

        // r fl fpc rr rv rd ir | req addr iv instr pc comp chk_pc
        // Two 32-bit instructions.
        vt.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,32'h00000013,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h4, 1,32'h00000013,32'h0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h00100093,1, 0,0, 1,32'h00000013,32'h0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h8, 1,32'h00100093,32'h4,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h8, 0,0,0,0,0));
        // Two compressed parcels in one word.
        vt.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h45014505,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h4, 1,32'h00004505,32'h0,1,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h4, 1,32'h00004501,32'h2,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h4, 0,0,0,0,0));
        // 32-bit instruction straddling a word boundary.
        vt.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h00134505,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h4, 1,32'h00004505,32'h0,1,0));
        vt.push_back(mk(0,0,0,1,0,0,1, 1,32'h4, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h00004501,1, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h8, 1,32'h45010013,32'h2,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h8, 1,32'h00000000,32'h6,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h8, 0,0,0,0,0));
        // Flush to a misaligned target while a request is outstanding.
        vt.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0, 0,0,0,0,0));
        vt.push_back(mk(0,1,32'h102,1,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 0,0, 0,0,32'h102,0,1));
        vt.push_back(mk(0,0,0,1,1,32'hDEADBEEF,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h100, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h45091234,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,1, 1,32'h104, 1,32'h00004509,32'h102,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h104, 0,0,0,0,0));
        // Flush together with a consume: no pop, PC jumps to the target.
        vt.push_back(mk(1,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h0, 0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1,32'h45014505,0, 0,0, 0,0,0,0,0));
        vt.push_back(mk(0,1,32'h40,0,0,0,1, 0,0, 1,32'h00004505,32'h0,1,0));
        vt.push_back(mk(0,0,0,1,0,0,0, 1,32'h40, 0,0,32'h40,0,1));
        vt.push_back(mk(0,0,0,0,1,32'h00134505,0, 0,0, 0,0,32'h40,0,1));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,32'h44, 1,32'h00004505,32'h40,1,0));

        for (int i = 0; i < vt.size(); i++) apply_vec(vt[i], i);

        // Reset while a request is outstanding; a late response must be ignored.
        rst = 1'b1; drive8(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
        rst = 1'b0; bus8.req_ready_i = 1'b1; #1;
        check1("rst_mid req_valid", bus8.req_valid_o, 1'b1); tick();
        bus8.req_ready_i = 1'b0; rst = 1'b1; #1;
        check1("rst_mid req_low", bus8.req_valid_o, 1'b0);
        check1("rst_mid iv_low", bus8.instr_valid_o, 1'b0); tick();
        rst = 1'b0; bus8.resp_valid_i = 1'b1; bus8.resp_data_i = 32'h45014505; #1;
        check1("rst_fall req_valid", bus8.req_valid_o, 1'b1); tick();
        bus8.resp_valid_i = 1'b0; #1;
        check1("stale_resp ignored", bus8.instr_valid_o, 1'b0);
        check("rst_fall req_addr", bus8.req_addr_o, 32'h0); tick();

        // DEPTH=4 occupancy limits with decode stalled.
        rst = 1'b1; tick(); rst = 1'b0;
        bus4.req_ready_i = 1'b1; #1;
        check1("d4 req1", bus4.req_valid_o, 1'b1); check("d4 addr0", bus4.req_addr_o, 32'h0); tick();
        bus4.req_ready_i = 1'b0; bus4.resp_valid_i = 1'b1; bus4.resp_data_i = 32'h45014505; #1;
        check1("d4 req_busy", bus4.req_valid_o, 1'b0); tick();
        bus4.resp_valid_i = 1'b0; bus4.req_ready_i = 1'b1; #1;
        check1("d4 req2", bus4.req_valid_o, 1'b1); check("d4 addr4", bus4.req_addr_o, 32'h4); tick();
        bus4.req_ready_i = 1'b0; bus4.resp_valid_i = 1'b1; bus4.resp_data_i = 32'h45034502; #1; tick();
        bus4.resp_valid_i = 1'b0; #1;
        check1("d4 full req", bus4.req_valid_o, 1'b0);
        check1("d4 full iv", bus4.instr_valid_o, 1'b1); tick();
        bus4.instr_ready_i = 1'b1; #1;
        check("d4 pop1 instr", bus4.instr_o, 32'h00004505); tick();
        bus4.instr_ready_i = 1'b0; #1;
        check1("d4 free1 req", bus4.req_valid_o, 1'b0); tick();
        bus4.instr_ready_i = 1'b1; #1;
        check("d4 pop2 instr", bus4.instr_o, 32'h00004501); tick();
        bus4.instr_ready_i = 1'b0; #1;
        check1("d4 free2 req", bus4.req_valid_o, 1'b1);
        check("d4 addr8", bus4.req_addr_o, 32'h8); tick();

        // Random traffic against the reference model.
        pend = 1'b0; dly = 0;
        mq.delete(); m_pc = 32'h0; m_fa = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r   = (c == 0) || ($urandom_range(199) == 0);
            fl  = ($urandom_range(24) == 0);
            fpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            rr  = ($urandom_range(2) != 0);
            ir  = ($urandom_range(3) != 0);
            rd  = $urandom;
            rv  = 1'b0;
            if (pend && dly == 0) begin
                rv = 1'b1; pend = 1'b0;
            end else if (!pend && $urandom_range(29) == 0) begin
                rv = 1'b1;
            end
            rst = r;
            drive8(fl, fpc, rr, rv, rd, ir);
            #1;
            m_req = !m_out && (8 - mq.size() >= 2) && !fl && !r;
            m_iv  = !r && ((mq.size() >= 2) || (mq.size() >= 1 && mq[0][1:0] != 2'b11));
            check1($sformatf("rnd%0d req_valid", c), bus8.req_valid_o, m_req);
            if (m_req) check($sformatf("rnd%0d req_addr", c), bus8.req_addr_o, m_fa);
            check1($sformatf("rnd%0d instr_valid", c), bus8.instr_valid_o, m_iv);
            if (m_iv) begin
                h0 = mq[0];
                e_instr = (h0[1:0] != 2'b11) ? {16'h0000, h0} : {mq[1], h0};
                check($sformatf("rnd%0d instr", c), bus8.instr_o, e_instr);
                check($sformatf("rnd%0d instr_pc", c), bus8.instr_pc_o, m_pc);
                check1($sformatf("rnd%0d compressed", c), bus8.instr_compressed_o, h0[1:0] != 2'b11);
            end
            if (pend && dly != 0) dly--;
            if (r) begin
                mq.delete(); m_out = 1'b0; m_drop = 1'b0; m_mis = 1'b0; m_pc = 32'h0; m_fa = 32'h0;
            end else if (fl) begin
                m_drop = m_out && !rv;
                m_out  = m_out && !rv;
                mq.delete();
                m_pc = fpc & ~32'h1; m_fa = fpc & ~32'h3; m_mis = fpc[1];
            end else begin
                if (m_iv && ir) begin
                    h0 = mq.pop_front();
                    if (h0[1:0] != 2'b11) m_pc = m_pc + 32'h2;
                    else begin void'(mq.pop_front()); m_pc = m_pc + 32'h4; end
                end
                if (rv && m_out) begin
                    m_out = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else if (m_mis) begin mq.push_back(rd[31:16]); m_mis = 1'b0; end
                    else begin mq.push_back(rd[15:0]); mq.push_back(rd[31:16]); end
                end
                if (m_req && rr) begin
                    m_out = 1'b1; m_fa = m_fa + 32'h4;
                    pend = 1'b1; dly = $urandom_range(2);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
